// File: rtl/spi_aes_slave_if.sv
// rtl/spi_aes_slave_if.sv - serial slave front-end that frames msg+key for an AES core and streams the result back
module spi_aes_slave_if #(
    parameter int nk = 8,
    parameter int nb = 4,
    parameter int nr = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 Mosi,
    input  logic                 in_valid,
    output logic                 Miso,
    output logic                 out_valid,
    output logic [32*nb-1:0]     core_msg,
    output logic [32*nk-1:0]     core_key,
    output logic                 core_start,
    input  logic [32*nb-1:0]     core_result,
    input  logic                 core_done,
    output logic                 busy
);

    localparam int KEY_W = 32 * nk;
    localparam int BLK_W = 32 * nb;
    localparam int FRAME = BLK_W + KEY_W;
    localparam int CNT_W = 9;

    // AES needs at least nk+6 rounds; catch a mismatched core configuration at elaboration.
    if (nr < nk + 6) begin : g_bad_rounds
        $error("spi_aes_slave_if: nr too small for nk");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_START,
        S_WAIT,
        S_TX
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [FRAME-2:0]   rx_shift;
    logic [BLK_W-1:0]   tx_shift;
    logic [FRAME-1:0]   rx_next;
    logic               accept;

    // The incoming bit joins the LSB; the full frame is visible on rx_next at the last bit.
    assign rx_next = {rx_shift, Mosi};
    assign accept  = cs & in_valid;
    assign busy    = (state != S_IDLE);

    // Frame receive, core handshake and result serialisation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            Miso       <= 1'b0;
            out_valid  <= 1'b0;
            core_start <= 1'b0;
            core_msg   <= '0;
            core_key   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rx_shift <= rx_next[FRAME-2:0];
                        count    <= CNT_W'(1);
                        state    <= S_RX;
                    end
                end
                S_RX: begin
                    if (!cs) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else if (in_valid) begin
                        rx_shift <= rx_next[FRAME-2:0];
                        if (count == CNT_W'(FRAME - 1)) begin
                            core_msg   <= rx_next[FRAME-1 -: BLK_W];
                            core_key   <= rx_next[KEY_W-1:0];
                            core_start <= 1'b1;
                            count      <= '0;
                            state      <= S_START;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                S_START: begin
                    core_start <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // The MSB goes straight onto Miso so the first bit appears the cycle after core_done.
                    if (core_done) begin
                        Miso      <= core_result[BLK_W-1];
                        tx_shift  <= {core_result[BLK_W-2:0], 1'b0};
                        out_valid <= 1'b1;
                        count     <= CNT_W'(1);
                        state     <= S_TX;
                    end
                end
                S_TX: begin
                    if (count == CNT_W'(BLK_W)) begin
                        Miso      <= 1'b0;
                        out_valid <= 1'b0;
                        count     <= '0;
                        state     <= S_IDLE;
                    end else begin
                        Miso     <= tx_shift[BLK_W-1];
                        tx_shift <= {tx_shift[BLK_W-2:0], 1'b0};
                        count    <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_aes_slave_if.sv
// tb/tb_spi_aes_slave_if.sv - randomized self-checking bench for spi_aes_slave_if (nk=8 and nk=4)
module tb_spi_aes_slave_if;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cur = 8;

    logic         cs_t = 1'b0, mosi_t = 1'b0, iv_t = 1'b0, done_t = 1'b0;
    logic [127:0] res_t = '0;

    logic         miso8, ov8, st8, busy8;
    logic [127:0] msg8;
    logic [255:0] key8;
    logic         miso4, ov4, st4, busy4;
    logic [127:0] msg4;
    logic [127:0] key4;

    spi_aes_slave_if #(.nk(8), .nb(4), .nr(14)) dut8 (
        .clk(clk), .rst(rst),
        .cs(cur == 8 ? cs_t : 1'b0), .Mosi(cur == 8 ? mosi_t : 1'b0),
        .in_valid(cur == 8 ? iv_t : 1'b0),
        .Miso(miso8), .out_valid(ov8), .core_msg(msg8), .core_key(key8),
        .core_start(st8), .core_result(cur == 8 ? res_t : 128'b0),
        .core_done(cur == 8 ? done_t : 1'b0), .busy(busy8)
    );

    spi_aes_slave_if #(.nk(4), .nb(4), .nr(10)) dut4 (
        .clk(clk), .rst(rst),
        .cs(cur == 4 ? cs_t : 1'b0), .Mosi(cur == 4 ? mosi_t : 1'b0),
        .in_valid(cur == 4 ? iv_t : 1'b0),
        .Miso(miso4), .out_valid(ov4), .core_msg(msg4), .core_key(key4),
        .core_start(st4), .core_result(cur == 4 ? res_t : 128'b0),
        .core_done(cur == 4 ? done_t : 1'b0), .busy(busy4)
    );

    logic         o_miso, o_valid, o_start, o_busy;
    logic [127:0] o_msg;
    logic [255:0] o_key;
    assign o_miso  = (cur == 8) ? miso8 : miso4;
    assign o_valid = (cur == 8) ? ov8   : ov4;
    assign o_start = (cur == 8) ? st8   : st4;
    assign o_busy  = (cur == 8) ? busy8 : busy4;
    assign o_msg   = (cur == 8) ? msg8  : msg4;
    assign o_key   = (cur == 8) ? key8  : {128'b0, key4};

    int n_pass = 0;
    int n_total = 0;
    int n_start = 0;

    always @(negedge clk) if (o_start) n_start++;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Frame bit i (first sent = 0) is fr[383-i].
    task automatic send_bits(input logic [383:0] fr, input int n, input bit stall, input bit noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1) chk("no_early_start", 256'(o_start), 256'(0));
            cs_t   = 1'b1;
            iv_t   = 1'b1;
            mosi_t = fr[383-i];
            done_t = noise && (i == 50);
            if (stall && (i % 7 == 6) && (i < n - 1)) begin
                @(negedge clk);
                iv_t   = 1'b0;
                mosi_t = 1'($urandom_range(0, 1));
                done_t = 1'b0;
            end
        end
    endtask

    task automatic finish_frame(input logic [127:0] msg, input logic [255:0] key, input logic [127:0] res,
                                input bit noise, input int rst_at, input int n0);
        logic [255:0] ekey;
        logic [127:0] got;
        int cnt;
        ekey = (cur == 8) ? key : {128'b0, key[127:0]};
        @(negedge clk);
        iv_t = 1'b0; cs_t = 1'b0; done_t = 1'b0;
        chk("start_latency", 256'(o_start), 256'(1));
        chk("core_msg", 256'(o_msg), 256'(msg));
        chk("core_key", o_key, ekey);
        res_t = res;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (noise) begin cs_t = 1'b1; iv_t = 1'b1; mosi_t = 1'($urandom_range(0, 1)); end
            if (k == 2) done_t = 1'b1;
        end
        @(negedge clk);
        done_t = 1'b0;
        chk("first_miso_latency", 256'(o_valid), 256'(1));
        chk("start_count", 256'(n_start - n0), 256'(1));
        got = '0;
        cnt = 0;
        while (o_valid && cnt < 200) begin
            got = {got[126:0], o_miso};
            cnt++;
            if (cnt == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_outputs", 256'({o_miso, o_valid, o_busy, o_start}), 256'(0));
                chk("rst_msg", 256'(o_msg), 256'(0));
                @(negedge clk);
                rst = 1'b0; cs_t = 1'b0; iv_t = 1'b0;
                return;
            end
            if (noise) begin cs_t = 1'($urandom_range(0, 1)); iv_t = 1'b1; mosi_t = 1'($urandom_range(0, 1)); end
            @(negedge clk);
        end
        cs_t = 1'b0; iv_t = 1'b0;
        chk("tx_len", 256'(cnt), 256'(128));
        chk("result", 256'(got), 256'(res));
        chk("idle_after_tx", 256'({o_busy, o_valid, o_miso}), 256'(0));
    endtask

    task automatic run(input logic [127:0] msg, input logic [255:0] key, input logic [127:0] res,
                       input bit stall, input bit noise, input int rst_at);
        logic [383:0] fr;
        int n0;
        n0 = n_start;
        fr = (cur == 8) ? {msg, key} : {msg, key[127:0], 128'b0};
        send_bits(fr, 128 + cur * 32, stall, noise);
        finish_frame(msg, key, res, noise, rst_at, n0);
    endtask

    localparam logic [127:0] FIPS_MSG  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] FIPS_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_RES  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_RES4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ABORT_MSG = 128'hfcf72a0bff39eefeff73f162b3d8e8d3;

    initial begin
        logic [383:0] fr;
        int n0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 256'({o_miso, o_valid, o_start, o_busy}), 256'(0));
        chk("reset_msg", 256'(o_msg), 256'(0));
        chk("reset_key", o_key, 256'(0));
        rst = 1'b0;

        run(FIPS_MSG, FIPS_KEY, FIPS_RES, 1'b0, 1'b0, -1);
        run(FIPS_MSG, FIPS_KEY, FIPS_RES, 1'b1, 1'b0, -1);

        n0 = n_start;
        fr = {FIPS_MSG, FIPS_KEY};
        send_bits(fr, 200, 1'b0, 1'b0);
        @(negedge clk);
        cs_t = 1'b0; iv_t = 1'b0;
        @(negedge clk);
        chk("abort_idle", 256'(o_busy), 256'(0));
        chk("abort_no_start", 256'(n_start - n0), 256'(0));
        run(ABORT_MSG, FIPS_KEY, FIPS_RES, 1'b0, 1'b0, -1);

        @(negedge clk); done_t = 1'b1;
        @(negedge clk); done_t = 1'b0;
        chk("done_in_idle", 256'({o_busy, o_valid}), 256'(0));
        run(FIPS_MSG, FIPS_KEY, FIPS_RES, 1'b0, 1'b1, -1);

        run(FIPS_MSG, FIPS_KEY, FIPS_RES, 1'b0, 1'b0, 60);
        run(FIPS_MSG, FIPS_KEY, FIPS_RES, 1'b0, 1'b0, -1);

        for (int t = 0; t < 4; t++)
            run(rnd128(), {rnd128(), rnd128()}, rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

        @(negedge clk);
        cur = 4;
        @(negedge clk);
        run(FIPS_MSG, {128'b0, FIPS_KEY[255:128]}, FIPS_RES4, 1'b0, 1'b0, -1);
        for (int t = 0; t < 2; t++)
            run(rnd128(), {128'b0, rnd128()}, rnd128(), 1'($urandom_range(0, 1)), 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
